// File: rtl/bpsk_tx_scheduler_pkg.sv
// Shared types and constants for the BPSK transmit frame scheduler.
// Exports: FSM state enum, default word width, default sync word.
package bpsk_tx_scheduler_pkg;

  localparam int WORD_W_DEF = 16;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5A5;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FETCH
  } sched_state_e;

endpackage

// File: rtl/bpsk_tx_scheduler_if.sv
// Word-source bundle between encoder channels and the scheduler.
// master: drives valid/data/last, samples ready. slave: the reverse.
interface bpsk_tx_scheduler_if #(
  parameter int NREQ   = 2,
  parameter int WORD_W = bpsk_tx_scheduler_pkg::WORD_W_DEF
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WORD_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/bpsk_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: req + last_grant -> gnt, gnt_idx.
// Search starts at last_grant+1 and wraps; gnt is one-hot or zero.
module bpsk_tx_scheduler_rr_arbiter
  import bpsk_tx_scheduler_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int IW = $clog2(NREQ);

  int best_d;
  int d;

  // Pick the requester with the smallest
  // rotated distance past last_grant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    best_d  = NREQ;
    d       = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (i > int'(last_grant))
        d = i - int'(last_grant) - 1;
      else
        d = i - int'(last_grant) - 1 + NREQ;
      if (req[i] && d < best_d) begin
        best_d  = d;
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/bpsk_tx_scheduler.sv
// Frame scheduler: RR-grants a source, sends sync + words to the modulator.
// Ports: clk, reset, req_if (slave), mod_word/mod_start, grant_id, busy, frame_done.
module bpsk_tx_scheduler
  import bpsk_tx_scheduler_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int MOD_CYCLES = 1160,
  parameter int GAP_CYCLES = 4,
  parameter logic [WORD_W-1:0] SYNC_WORD =
    WORD_W'(SYNC_WORD_DEF)
) (
  input  logic                    clk,
  input  logic                    reset,
  bpsk_tx_scheduler_if.slave      req_if,
  output logic [WORD_W-1:0]       mod_word,
  output logic                    mod_start,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int GW  = $clog2(NREQ);
  localparam int CW  = $clog2(MOD_CYCLES + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0]  MOD_LAST =
    CW'(MOD_CYCLES - 1);
  localparam logic [GCW-1:0] GAP_LAST =
    GCW'(GAP_CYCLES - 1);

  sched_state_e    state;
  logic [GW-1:0]   last_grant;
  logic            last_flag;
  logic [CW-1:0]   mod_cnt;
  logic [GCW-1:0]  gap_cnt;

  logic [NREQ-1:0] arb_gnt;
  logic [GW-1:0]   arb_idx;
  logic            req_any;
  logic            xfer;
  logic [NREQ-1:0] ready;

  logic [WORD_W-1:0] words [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign words[i] =
      req_if.req_data[i*WORD_W +: WORD_W];
  end

  bpsk_tx_scheduler_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req        (req_if.req_valid),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  assign req_any = |arb_gnt;

  assign xfer = (state == FETCH) &&
                req_if.req_valid[grant_id];

  // Ready is held for the owner through a
  // FETCH stall, so it pulses once per word.
  always_comb begin
    ready = '0;
    if (state == FETCH)
      ready[grant_id] = 1'b1;
  end

  assign req_if.req_ready = ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mod_start  <= 1'b0;
      mod_word   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      grant_id   <= '0;
      last_grant <= GW'(NREQ - 1);
      last_flag  <= 1'b0;
      mod_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_any) begin
            grant_id   <= arb_idx;
            last_grant <= arb_idx;
            mod_word   <= SYNC_WORD;
            last_flag  <= 1'b0;
            mod_start  <= 1'b1;
            busy       <= 1'b1;
            mod_cnt    <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (mod_cnt == MOD_LAST) begin
            mod_start <= 1'b0;
            gap_cnt   <= '0;
            state     <= GAP;
          end else begin
            mod_cnt <= mod_cnt + CW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (last_flag) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        FETCH: begin
          if (xfer) begin
            mod_word  <= words[grant_id];
            last_flag <= req_if.req_last[grant_id];
            mod_start <= 1'b1;
            mod_cnt   <= '0;
            state     <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Bench for bpsk_tx_scheduler: random frames vs a frame-level model.
// Monitors mod_start runs, ready pulses and frame_done timing.
module tb_bpsk_tx_scheduler;

  localparam int NREQ = 2;
  localparam int WW   = 16;
  localparam int MODC = 20;
  localparam int GAPC = 4;
  localparam int PER  = MODC + GAPC + 1;
  localparam int STALL = 30;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WW-1:0] mod_word;
  logic          mod_start;
  logic [0:0]    grant_id;
  logic          busy;
  logic          frame_done;

  bpsk_tx_scheduler_if #(
    .NREQ(NREQ), .WORD_W(WW)
  ) bus ();

  bpsk_tx_scheduler #(
    .NREQ       (NREQ),
    .WORD_W     (WW),
    .MOD_CYCLES (MODC),
    .GAP_CYCLES (GAPC),
    .SYNC_WORD  (16'hA5A5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_if     (bus.slave),
    .mod_word   (mod_word),
    .mod_start  (mod_start),
    .grant_id   (grant_id),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } wd_t;

  wd_t q0[$], q1[$], mq0[$], mq1[$];

  logic [15:0] exp_w[$];
  int          exp_g[$];
  int          exp_per[$];
  int          frames_exp, model_last;
  int          exp_r0, exp_r1;

  logic [15:0] sent_w[$];
  int          sent_g[$];
  int          rise_c[$];
  int          hi_len[$];
  int          fd_delta[$];
  logic        fd_busy[$];

  int          cyc_n, run, last_fall;
  int          unstable, bad_ready, bad_busy;
  int          rdy_p0, rdy_p1;
  logic        prev_s;
  logic [1:0]  prev_r;
  logic [15:0] cur_w;

  int          hold1, ret_c;
  bit          stall_arm, ret_pend;

  int          n_pass, n_fail, n_total;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, want);
    end
  endtask

  task automatic add_word(int r, logic [15:0] d,
                          logic l);
    wd_t w;
    w.d = d;
    w.l = l;
    if (r == 0) begin
      q0.push_back(w);
      mq0.push_back(w);
    end else begin
      q1.push_back(w);
      mq1.push_back(w);
    end
  endtask

  task automatic drive();
    if (q0.size() > 0) begin
      bus.req_valid[0]    = 1'b1;
      bus.req_data[15:0]  = q0[0].d;
      bus.req_last[0]     = q0[0].l;
    end else begin
      bus.req_valid[0]    = 1'b0;
      bus.req_data[15:0]  = '0;
      bus.req_last[0]     = 1'b0;
    end
    if (q1.size() > 0) begin
      bus.req_data[31:16] = q1[0].d;
      bus.req_last[1]     = q1[0].l;
    end else begin
      bus.req_data[31:16] = '0;
      bus.req_last[1]     = 1'b0;
    end
    if (hold1 > 0) begin
      hold1--;
      bus.req_valid[1] = 1'b0;
      if (hold1 == 0) ret_pend = 1'b1;
    end else begin
      bus.req_valid[1] = (q1.size() > 0);
      if (ret_pend) begin
        ret_c    = cyc_n;
        ret_pend = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    if (mod_start && !prev_s) begin
      sent_w.push_back(mod_word);
      sent_g.push_back(int'(grant_id));
      rise_c.push_back(cyc_n);
      cur_w = mod_word;
      run   = 0;
    end
    if (mod_start) begin
      run++;
      if (mod_word !== cur_w) unstable++;
      if (!busy) bad_busy++;
    end
    if (!mod_start && prev_s) begin
      hi_len.push_back(run);
      last_fall = cyc_n;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i] &&
          (i != int'(grant_id) || !busy))
        bad_ready++;
      if (bus.req_ready[i] && !prev_r[i]) begin
        if (i == 0) rdy_p0++;
        else        rdy_p1++;
      end
    end
    if (frame_done) begin
      fd_delta.push_back(cyc_n - last_fall);
      fd_busy.push_back(busy);
    end
    prev_s = mod_start;
    prev_r = bus.req_ready;
  endtask

  task automatic cyc();
    logic [1:0] fire;
    fire = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    cyc_n++;
    if (fire[0]) void'(q0.pop_front());
    if (fire[1]) begin
      void'(q1.pop_front());
      if (stall_arm) begin
        stall_arm = 1'b0;
        hold1     = MODC + GAPC + STALL;
      end
    end
    drive();
    monitor();
  endtask

  task automatic clear_rec();
    sent_w.delete();
    sent_g.delete();
    rise_c.delete();
    hi_len.delete();
    fd_delta.delete();
    fd_busy.delete();
    exp_w.delete();
    exp_g.delete();
    exp_per.delete();
    frames_exp = 0;
    exp_r0     = 0;
    exp_r1     = 0;
    unstable   = 0;
    bad_ready  = 0;
    bad_busy   = 0;
    rdy_p0     = 0;
    rdy_p1     = 0;
  endtask

  // Frame-level model: round-robin over
  // requesters with pending frames; each
  // frame is sync then its words.
  task automatic build_model();
    while (mq0.size() > 0 || mq1.size() > 0) begin
      int  r;
      wd_t w;
      r = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (model_last + k) % NREQ;
        if (r < 0 &&
            ((c == 0 && mq0.size() > 0) ||
             (c == 1 && mq1.size() > 0)))
          r = c;
      end
      exp_w.push_back(16'hA5A5);
      exp_g.push_back(r);
      exp_per.push_back(-1);
      do begin
        if (r == 0) w = mq0.pop_front();
        else        w = mq1.pop_front();
        exp_w.push_back(w.d);
        exp_g.push_back(r);
        exp_per.push_back(PER);
        if (r == 0) exp_r0++;
        else        exp_r1++;
      end while (!w.l);
      frames_exp++;
      model_last = r;
    end
  endtask

  task automatic run_frames(int budget);
    int n;
    n = 0;
    while (fd_delta.size() < frames_exp &&
           n < budget) begin
      cyc();
      n++;
    end
    check("frames_in_time",
          32'(fd_delta.size() >= frames_exp), 1);
    repeat (3) cyc();
  endtask

  task automatic verify();
    check("word_count", sent_w.size(),
          exp_w.size());
    for (int j = 0; j < exp_w.size() &&
                    j < sent_w.size(); j++) begin
      check("word", sent_w[j], exp_w[j]);
      check("grant", sent_g[j], exp_g[j]);
      if (j > 0 && exp_per[j] >= 0)
        check("word_period",
              rise_c[j] - rise_c[j-1],
              exp_per[j]);
    end
    foreach (hi_len[j])
      check("start_hold", hi_len[j], MODC);
    check("frame_done_count", fd_delta.size(),
          frames_exp);
    foreach (fd_delta[j]) begin
      check("frame_done_delay", fd_delta[j],
            GAPC);
      check("busy_at_done", fd_busy[j], 0);
    end
    check("ready0_pulses", rdy_p0, exp_r0);
    check("ready1_pulses", rdy_p1, exp_r1);
    check("word_stable", unstable, 0);
    check("ready_owner", bad_ready, 0);
    check("busy_in_send", bad_busy, 0);
    check("busy_idle", busy, 0);
    check("start_idle", mod_start, 0);
  endtask

  initial begin
    int n;
    int start_c;
    n_pass     = 0;
    n_fail     = 0;
    n_total    = 0;
    cyc_n      = 0;
    run        = 0;
    last_fall  = 0;
    prev_s     = 1'b0;
    prev_r     = '0;
    cur_w      = '0;
    hold1      = 0;
    ret_c      = 0;
    stall_arm  = 1'b0;
    ret_pend   = 1'b0;
    model_last = NREQ - 1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    clear_rec();

    repeat (3) cyc();
    check("rst_mod_start", mod_start, 0);
    check("rst_mod_word", mod_word, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_grant", grant_id, 0);
    reset = 1'b0;
    cyc();

    // Reset in the middle of SEND.
    add_word(0, 16'($urandom), 1'b1);
    drive();
    n = 0;
    while (!mod_start && n < 10) begin
      cyc();
      n++;
    end
    repeat (5) cyc();
    check("send_before_reset", mod_start, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_start", mod_start, 0);
    check("async_reset_busy", busy, 0);
    q0.delete();
    mq0.delete();
    drive();
    repeat (2) cyc();
    reset = 1'b0;
    clear_rec();
    model_last = NREQ - 1;
    repeat (10) cyc();
    check("no_done_after_reset",
          fd_delta.size(), 0);
    check("idle_after_reset", busy, 0);
    check("no_start_after_reset",
          sent_w.size(), 0);
    clear_rec();

    // Both requesters valid: frames alternate.
    for (int r = 0; r < NREQ; r++) begin
      for (int f = 0; f < 2; f++) begin
        int len;
        len = int'($urandom_range(1, 3));
        for (int k = 0; k < len; k++)
          add_word(r, 16'($urandom),
                   logic'(k == len - 1));
      end
    end
    build_model();
    drive();
    run_frames(1200);
    verify();
    clear_rec();

    // Directed two-word frame from req0.
    add_word(0, 16'h1234, 1'b0);
    add_word(0, 16'hBEEF, 1'b1);
    build_model();
    drive();
    start_c = cyc_n;
    run_frames(300);
    check("seen_rises", rise_c.size(), 3);
    if (rise_c.size() > 0)
      check("idle_latency",
            rise_c[0] - start_c, 1);
    verify();
    clear_rec();

    // req1 drops valid across FETCH.
    add_word(1, 16'($urandom), 1'b0);
    add_word(1, 16'($urandom), 1'b1);
    build_model();
    exp_per[2] += STALL;
    stall_arm = 1'b1;
    drive();
    run_frames(400);
    check("stall_rises", rise_c.size(), 3);
    if (rise_c.size() > 2)
      check("resume_latency",
            rise_c[2] - ret_c, 1);
    verify();
    clear_rec();

    // Single-word frame.
    add_word(0, 16'h0001, 1'b1);
    build_model();
    drive();
    run_frames(200);
    verify();
    clear_rec();

    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bpsk_tx_scheduler.md
Name: bpsk_tx_scheduler

Overview:
- Frame-level controller in front of the 16-bit BPSK modulator.
- Arbitrates round-robin between NREQ word sources (encoder channels). Locks the grant for one frame.
- Prefixes each frame with a fixed sync word, then sequences each word into the modulator by holding its start line for a fixed word duration.
- Drops start between words so the modulator re-arms from its idle state.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WORD_W, 16, modulator word width.
- MOD_CYCLES, 1160, clocks mod_start is held high per word. Must be ≥ the modulator's full 16-bit on/off transmission time.
- GAP_CYCLES, 4, clocks mod_start is held low between words (≥2).
- SYNC_WORD, 16'hA5A5, preamble word sent first in every frame.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a word on its data slice
- req_data  in  NREQ*WORD_W  slice i = word of requester i
- req_last  in  NREQ  word of requester i is the last of its frame
- req_ready  out  NREQ  one-hot, one-cycle accept pulse; a word transfers when valid&ready
- mod_word  out  WORD_W  word presented to the modulator; stable while mod_start=1
- mod_start  out  1  modulator start/hold
- grant_id  out  $clog2(NREQ)  requester owning the current frame
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last word's gap completes

Behaviour:
- Reset (async, any state): state=IDLE; mod_start=0; mod_word=0; req_ready=0; busy=0; frame_done=0; grant_id=0; last_grant=NREQ-1; counters=0. Mid-frame reset abandons the frame with no frame_done pulse.
- IDLE:
  - If any req_valid, pick the first set bit searching from last_grant+1 with wrap-around.
  - Register grant_id and last_grant; mod_word<=SYNC_WORD; last_flag<=0; go SEND.
  - Requester data is not consumed here.
- SEND: mod_start=1 for exactly MOD_CYCLES consecutive clocks, then go GAP with mod_start=0 on the next clock.
- GAP: mod_start=0 for exactly GAP_CYCLES clocks, then:
  - if last_flag=1: pulse frame_done for one cycle, go IDLE;
  - else go FETCH.
- FETCH: req_ready[grant_id]=1 combinationally while req_valid[grant_id]=0 or on the transfer cycle.
  - On the transfer cycle: mod_word<=req_data slice; last_flag<=req_last[grant_id]; go SEND.
  - Waits indefinitely with mod_start=0. Other requesters are ignored until the frame ends.
- req_ready is only ever asserted for grant_id, and only in FETCH.
- Latency: request in IDLE → mod_start high 1 clock later. Data transfer in FETCH → mod_start high 1 clock later.
- Word period when data is waiting: MOD_CYCLES+GAP_CYCLES+1 clocks.
- Simultaneous requests: round-robin only. With both always valid, frames alternate 0,1,0,1…
- A requester dropping valid in FETCH stalls the scheduler; mod_start stays 0.
- Counter widths: $clog2(MOD_CYCLES+1) bits and $clog2(GAP_CYCLES+1) bits. Counters clear on every state entry.

Decomposition:
- Shared package: state enum (IDLE, SEND, GAP, FETCH); SYNC_WORD default; word-width constant.
- One sub-module, rr_arbiter (NREQ request vector + last_grant → one-hot grant + index, combinational), so it is reusable by the receive side.

Test Plan (MOD_CYCLES=20, GAP_CYCLES=4):
- Reset asserted mid-SEND → mod_start falls in the same cycle without a clock edge. After release: busy=0, no frame_done.
- Req0 frame of words 16'h1234, 16'hBEEF (last on second) → mod_word sequence A5A5, 1234, BEEF. Each is held with mod_start=1 for 20 clocks, with 4-clock low gaps. Exactly 2 req_ready[0] pulses. frame_done 4 clocks after BEEF's start falls.
- Req0 and req1 both valid in IDLE with last_grant=1 → grant_id=0 first. Next frame grant_id=1. Req1 sees no req_ready during frame 0.
- Req1 drops valid for 30 clocks in FETCH → mod_start stays 0 for those 30 clocks. Transmission resumes 1 clock after valid returns.
- Single-word frame (req_last=1 on first word 16'h0001) → A5A5 then 0001, then frame_done, then IDLE. busy falls with the frame_done pulse.
